// File: rtl/io_bus_ctrl.sv
// I/O bus sequencer: turns a single-cycle CPU I/O access into a req/ack handshake
// with one of NUM_PERIPH peripheral slots, stalling the CPU until it completes.
// Optional macro IO_TIMEOUT_EN aborts a request left unacknowledged for TIMEOUT cycles.
module io_bus_ctrl #(
  parameter int NUM_PERIPH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [9:0]            io_addr,
  input  logic [31:0]           io_wdata,
  output logic [31:0]           io_rdata,
  output logic                  stall,
  output logic                  io_err,
  output logic [NUM_PERIPH-1:0] periph_sel,
  output logic                  periph_req,
  output logic                  periph_we,
  output logic [3:0]            periph_addr,
  output logic [31:0]           periph_wdata,
  input  logic [NUM_PERIPH-1:0] periph_ack,
  input  logic [31:0]           periph_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, next_state;

  logic                  access;
  logic                  mapped;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  err_q;
  logic [NUM_PERIPH-1:0] sel_dec;

  assign access = io_read | io_write;
  assign mapped = (io_addr[9:8] == 2'b00) && ({1'b0, io_addr[7:4]} < 5'(NUM_PERIPH));

  always_comb begin
    for (int i = 0; i < NUM_PERIPH; i++) begin
      sel_dec[i] = (io_addr[7:4] == 4'(i));
    end
  end

  // periph_sel is one-hot and already registered in REQ, so masking avoids a
  // variable index into a possibly narrower ack vector.
  assign ack_hit = |(periph_ack & periph_sel);

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The TIMEOUT-th REQ cycle is the last one; an ack in that cycle still wins.
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == REQ) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps all paths assigned,
    // which is what prevents latch inference.
    next_state = state;
    unique case (state)
      IDLE: if (access) next_state = mapped ? REQ : DONE;
      REQ:  if (ack_hit || timeout_hit) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    stall  = ((state == IDLE) && access) || (state == REQ);
    io_err = (state == DONE) && err_q;
  end

  // Bus-side registers and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      periph_req   <= 1'b0;
      periph_sel   <= '0;
      periph_we    <= 1'b0;
      periph_addr  <= '0;
      periph_wdata <= '0;
      io_rdata     <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            periph_we    <= io_write;
            periph_addr  <= io_addr[3:0];
            periph_wdata <= io_wdata;
            if (mapped) begin
              periph_req <= 1'b1;
              periph_sel <= sel_dec;
              err_q      <= 1'b0;
            end else begin
              err_q <= 1'b1;
              if (!io_write) io_rdata <= '0;
            end
          end
        end
        REQ: begin
          if (ack_hit) begin
            periph_req <= 1'b0;
            periph_sel <= '0;
            err_q      <= 1'b0;
            if (!periph_we) io_rdata <= periph_rdata;
          end else if (timeout_hit) begin
            periph_req <= 1'b0;
            periph_sel <= '0;
            err_q      <= 1'b1;
            if (!periph_we) io_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed cases plus randomized accesses
// compared against a transaction-level model of latency, error and read data.
module tb_io_bus_ctrl;

  localparam int NP  = 4;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_read, io_write;
  logic [9:0]    io_addr;
  logic [31:0]   io_wdata;
  logic [31:0]   io_rdata;
  logic          stall, io_err;
  logic [NP-1:0] periph_sel;
  logic          periph_req, periph_we;
  logic [3:0]    periph_addr;
  logic [31:0]   periph_wdata;
  logic [NP-1:0] periph_ack;
  logic [31:0]   periph_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;

  io_bus_ctrl #(.NUM_PERIPH(NP), .TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_read      (io_read),
    .io_write     (io_write),
    .io_addr      (io_addr),
    .io_wdata     (io_wdata),
    .io_rdata     (io_rdata),
    .stall        (stall),
    .io_err       (io_err),
    .periph_sel   (periph_sel),
    .periph_req   (periph_req),
    .periph_we    (periph_we),
    .periph_addr  (periph_addr),
    .periph_wdata (periph_wdata),
    .periph_ack   (periph_ack),
    .periph_rdata (periph_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One CPU I/O instruction issued in IDLE. k = REQ cycle (1-based) in which the
  // slot acks, 0 = never. spur pulses the neighbouring slot's ack before that.
  task automatic access(input logic rd, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wd, input int k, input logic [31:0] rdat,
                        input bit spur);
    bit          mapped, timed_out, done;
    int          exp_req, stall_cnt, req_cnt, bus_bad, other;
    logic        exp_err;
    logic [NP-1:0] exp_sel;

    mapped    = (addr[9:8] == 2'b00) && (int'(addr[7:4]) < NP);
    timed_out = 1'b0;
`ifdef IO_TIMEOUT_EN
    if (mapped && (k == 0 || k > TMO)) timed_out = 1'b1;
`endif
    exp_req = !mapped ? 0 : (timed_out ? TMO : k);
    exp_err = !mapped || timed_out;
    exp_sel = mapped ? NP'(1 << addr[7:4]) : '0;
    other   = (int'(addr[7:4]) + NP - 1) % NP;
    if (!wr) model_rdata = (!mapped || timed_out) ? 32'h0 : rdat;

    io_read  = rd;
    io_write = wr;
    io_addr  = addr;
    io_wdata = wd;
    #1;
    stall_cnt = 0;
    req_cnt   = 0;
    bus_bad   = 0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stall) stall_cnt++;
      if (periph_req) begin
        req_cnt++;
        if (periph_sel !== exp_sel || periph_we !== wr || periph_addr !== addr[3:0] ||
            (wr && periph_wdata !== wd)) bus_bad++;
        periph_ack   = '0;
        periph_rdata = $urandom;
        if (spur && req_cnt < k) periph_ack[other] = 1'b1;
        if (req_cnt == k) begin
          periph_ack   = periph_ack | exp_sel;
          periph_rdata = rdat;
        end
      end else if (cyc > 0) begin
        periph_ack = '0;
        done       = 1'b1;
        break;
      end
      tick();
    end

    check("done_reached", 32'(done), 32'd1);
    check("stall_cycles", stall_cnt, 1 + exp_req);
    check("req_cycles", req_cnt, exp_req);
    check("bus_fields", bus_bad, 0);
    if (done) begin
      check("err_in_done", 32'(io_err), 32'(exp_err));
      check("sel_in_done", 32'(periph_sel), 32'd0);
      check("rdata_in_done", io_rdata, model_rdata);
    end
    io_read  = 1'b0;
    io_write = 1'b0;
    tick();
    check("err_after_done", 32'(io_err), 32'd0);
    check("rdata_held", io_rdata, model_rdata);
    check("stall_idle", 32'(stall), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    io_addr      = '0;
    io_wdata     = '0;
    periph_ack   = '0;
    periph_rdata = '0;
    #12;
    check("rst_req", 32'(periph_req), 32'd0);
    check("rst_sel", 32'(periph_sel), 32'd0);
    check("rst_we", 32'(periph_we), 32'd0);
    check("rst_addr", 32'(periph_addr), 32'd0);
    check("rst_wdata", periph_wdata, 32'd0);
    check("rst_rdata", io_rdata, 32'd0);
    check("rst_err", 32'(io_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Directed cases.
    access(1'b1, 1'b0, 10'h010, 32'h0, 1, 32'h0000_00A5, 1'b0);
    access(1'b0, 1'b1, 10'h023, 32'h1234_5678, 5, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, 10'h050, 32'h0, 1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 10'h000, 32'h0, 4, 32'hCAFE_F00D, 1'b1);
    access(1'b1, 1'b1, 10'h031, 32'hA5A5_0001, 2, 32'h7777_7777, 1'b0);
    access(1'b0, 1'b1, 10'h110, 32'h0BAD_0BAD, 1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 10'h03F, 32'h0, 3, 32'hFFFF_0000, 1'b1);

    // Randomized accesses, issued back to back.
    for (int n = 0; n < 40; n++) begin
      logic       rd, wr;
      logic [9:0] a;
      int         sel;
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      a   = 10'($urandom);
      if ($urandom_range(0, 3) != 0) a[9:8] = 2'b00;
      if ($urandom_range(0, 3) != 0) a[7:6] = 2'b00;
      access(rd, wr, a, $urandom, int'($urandom_range(1, 6)), $urandom,
             1'($urandom_range(0, 1)));
    end

    // Reset in the second REQ cycle.
    io_read = 1'b1;
    io_addr = 10'h010;
    tick();
    tick();
    check("midreq_req_before", 32'(periph_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midreq_req_async", 32'(periph_req), 32'd0);
    check("midreq_sel_async", 32'(periph_sel), 32'd0);
    check("midreq_rdata", io_rdata, 32'd0);
    model_rdata = '0;
    io_read = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreq_no_err", 32'(io_err), 32'd0);
      check("midreq_idle_stall", 32'(stall), 32'd0);
      check("midreq_idle_req", 32'(periph_req), 32'd0);
    end
    access(1'b1, 1'b0, 10'h020, 32'h0, 2, 32'h1357_9BDF, 1'b0);

    // Unacknowledged request.
`ifdef IO_TIMEOUT_EN
    access(1'b1, 1'b0, 10'h020, 32'h0, 0, 32'h0, 1'b0);
`else
    begin
      int hi;
      hi       = 0;
      io_read  = 1'b1;
      io_addr  = 10'h020;
      periph_ack = '0;
      #1;
      for (int i = 0; i < 1000; i++) begin
        if (stall) hi++;
        tick();
      end
      check("hang_stall", hi, 1000);
      check("hang_req", 32'(periph_req), 32'd1);
      check("hang_no_err", 32'(io_err), 32'd0);
      io_read = 1'b0;
      reset   = 1'b0;
      model_rdata = '0;
      tick();
      reset = 1'b1;
      tick();
    end
`endif
    access(1'b1, 1'b0, 10'h030, 32'h0, 1, 32'h2468_ACE0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
